// File: rtl/sp1_ram_ctrl_pkg.sv
// Shared encodings for the sp1_ram initiator and its response FIFO.
package sp1_ram_ctrl_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  localparam int RSP_DEPTH = 4;
  localparam int RSP_CW    = $clog2(RSP_DEPTH + 1);
endpackage

// File: rtl/sp1_rsp_fifo.sv
// Small synchronous FIFO (power-of-two depth) with simultaneous push/pop.
module sp1_rsp_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
  assign w_pop  = pop & (r_count != '0);
  assign w_push = push & ((r_count != CW'(DEPTH)) | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end

  assign dout  = r_mem[r_rp];
  assign count = r_count;
  assign empty = (r_count == '0);
endmodule

// File: rtl/sp1_ram_ctrl.sv
// Burst initiator for the sp1_ram single-port RAM: request channel in,
// write-data stream in, buffered read-data stream out.
module sp1_ram_ctrl
  import sp1_ram_ctrl_pkg::*;
#(
  parameter int AW = 6,
  parameter int DW = 32,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_adr,
  input  logic [LW-1:0] req_len,
  input  logic          wd_valid,
  output logic          wd_ready,
  input  logic [DW-1:0] wd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          wr_done,
  output logic          busy,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);
  state_t            r_state;
  logic [AW-1:0]     r_addr;
  logic [LW-1:0]     r_cnt;
  logic              r_inflight, r_inflight_last, r_wr_done;
  logic [DW-1:0]     r_din;

  logic [DW:0]       w_fifo_dout;
  logic [RSP_CW-1:0] w_count, w_occ;
  logic              w_empty, w_rd_issue, w_wr_beat, w_pop;

  // Slots already promised (buffered + one read in the RAM pipe) gate each new issue.
  assign w_occ      = w_count + RSP_CW'(r_inflight);
  assign w_rd_issue = (r_state == S_RD) && (w_occ < RSP_CW'(RSP_DEPTH));
  assign w_wr_beat  = (r_state == S_WR) && wd_valid;
  assign w_pop      = rd_valid & rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_cnt           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_wr_done       <= 1'b0;
      r_din           <= '0;
    end else begin
      r_inflight      <= w_rd_issue;
      r_inflight_last <= w_rd_issue && (r_cnt == '0);
      r_wr_done       <= w_wr_beat && (r_cnt == '0);
      if (w_wr_beat) r_din <= wd_data;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_addr  <= req_adr;
          r_cnt   <= req_len;
          r_state <= req_we ? S_WR : S_RD;
        end
        S_RD: if (w_rd_issue) begin
          r_addr <= r_addr + AW'(1);
          r_cnt  <= r_cnt - LW'(1);
          if (r_cnt == '0) r_state <= S_IDLE;
        end
        S_WR: if (w_wr_beat) begin
          r_addr <= r_addr + AW'(1);
          r_cnt  <= r_cnt - LW'(1);
          if (r_cnt == '0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM output is captured one edge after the issue, tagged with its last flag.
  sp1_rsp_fifo #(
    .W     (DW + 1),
    .DEPTH (RSP_DEPTH),
    .CW    (RSP_CW)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_inflight),
    .din   ({r_inflight_last, ram_dout}),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .count (w_count),
    .empty (w_empty)
  );

  assign req_ready = (r_state == S_IDLE) & ~rst;
  assign wd_ready  = (r_state == S_WR);
  assign rd_valid  = ~w_empty;
  assign rd_data   = w_fifo_dout[DW-1:0];
  assign rd_last   = ~w_empty & w_fifo_dout[DW];
  assign wr_done   = r_wr_done;
  assign busy      = (r_state != S_IDLE) | r_inflight | ~w_empty;

  // The RAM corrupts mem[adr] when deselected, so it stays selected whenever out of reset.
  assign ram_cs  = ~rst;
  assign ram_we  = w_wr_beat;
  assign ram_adr = r_addr;
  assign ram_din = w_wr_beat ? wd_data : r_din;
endmodule

// File: tb/tb_sp1_ram_ctrl.sv
// Scoreboard bench for sp1_ram_ctrl with a behavioural sp1_ram attached.
module tb_sp1_ram_ctrl;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam logic [31:0] CLOB = 32'hDEAD_DEAD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0;
  logic [AW-1:0] req_adr = '0;
  logic [LW-1:0] req_len = '0;
  logic          wd_valid = 1'b0;
  logic [DW-1:0] wd_data = '0;
  logic          rd_ready = 1'b1;
  logic          req_ready, wd_ready, rd_valid, rd_last, wr_done, busy;
  logic [DW-1:0] rd_data;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_din, ram_dout;

  int n_chk = 0, n_fail = 0;
  int ram_warn = 0, hyg_err = 0, wr_done_cnt = 0;

  logic [31:0] ram_mem [64];
  logic [31:0] ref_mem [64];
  logic [32:0] rq [$];
  logic [37:0] wq [$];

  always #5 clk = ~clk;

  sp1_ram_ctrl #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .wr_done(wr_done), .busy(busy),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural sp1_ram: deselect clobbers the addressed word.
  logic [31:0] ram_dout_r = '0;
  assign ram_dout = ram_dout_r;
  always @(posedge clk) begin
    if ($isunknown(ram_cs) || (ram_cs && ($isunknown(ram_we) || $isunknown(ram_adr) || $isunknown(ram_din))))
      ram_warn++;
    else if (!ram_cs) ram_mem[ram_adr] <= CLOB;
    else if (ram_we) ram_mem[ram_adr] <= ram_din;
    else ram_dout_r <= ram_mem[ram_adr];
  end

  // Monitor: read responses and RAM writes against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      logic [32:0] e;
      logic [37:0] w;
      if (ram_cs !== 1'b1 || $isunknown(ram_adr) || $isunknown(ram_din)) hyg_err++;
      if (wr_done === 1'b1) wr_done_cnt++;
      if (rd_valid === 1'b1 && rd_ready) begin
        if (rq.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          e = rq.pop_front();
          chk("rd_data", rd_data, e[31:0]);
          chk("rd_last", rd_last, e[32]);
        end
      end
      if (ram_cs === 1'b1 && ram_we === 1'b1) begin
        if (wq.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          w = wq.pop_front();
          chk("wr_adr", ram_adr, w[37:32]);
          chk("wr_data", ram_din, w[31:0]);
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_wd_ready"}, wd_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_last"}, rd_last, 0);
    chk({tag, "_wr_done"}, wr_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ram_cs"}, ram_cs, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_adr"}, ram_adr, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
  endtask

  task automatic send_req(input logic we, input logic [AW-1:0] adr, input logic [LW-1:0] len);
    bit ok = 0;
    req_valid = 1'b1; req_we = we; req_adr = adr; req_len = len;
    if (!we)
      for (int i = 0; i <= int'(len); i++) begin
        logic [AW-1:0] a = adr + AW'(i);
        rq.push_back({(i == int'(len)), ref_mem[a]});
      end
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) chk("req_accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [AW-1:0] adr, input logic [LW-1:0] len,
                             input logic [31:0] base, input bit gaps);
    int i = 0;
    int c = 0;
    send_req(1'b1, adr, len);
    while (i <= int'(len)) begin
      if (gaps && c[0]) begin
        wd_valid = 1'b0;
        @(negedge clk);
        chk("gap_ram_we", ram_we, 0);
        chk("gap_ram_cs", ram_cs, 1);
      end else begin
        logic [AW-1:0] a = adr + AW'(i);
        wd_valid = 1'b1;
        wd_data  = base + 32'(i);
        wq.push_back({a, wd_data});
        ref_mem[a] = wd_data;
        i++;
      end
      c++;
      @(posedge clk); #1;
    end
    wd_valid = 1'b0;
    @(negedge clk);
    chk("wr_done_pulse", wr_done, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!busy && rq.size() == 0 && wq.size() == 0) ok = 1;
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int idle_err = 0;
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = 32'hC0DE_0000 + 32'(i);
      ref_mem[i] = 32'hC0DE_0000 + 32'(i);
    end
    #1;
    chk_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ref_mem[0] = CLOB;

    // Idle hygiene
    repeat (50) begin
      @(negedge clk);
      if (ram_cs !== 1'b1 || ram_we !== 1'b0 || $isunknown(ram_adr) || $isunknown(ram_din)) idle_err++;
    end
    chk("idle_hygiene", idle_err, 0);
    chk("idle_req_ready", req_ready, 1);
    @(posedge clk); #1;

    // Wrapping write burst and read-back
    wr_done_cnt = 0;
    write_burst(6'h3E, 4'd3, 32'h0000_00A0, 1'b0);
    wait_idle();
    chk("wr_done_once", wr_done_cnt, 1);
    send_req(1'b0, 6'h3E, 4'd3);
    wait_idle();

    // Single read latency and busy release
    write_burst(6'h05, 4'd0, 32'h1234_5678, 1'b0);
    wait_idle();
    send_req(1'b0, 6'h05, 4'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (rd_valid) break;
    end
    chk("rd_latency", n, 3);
    chk("single_rd_last", rd_last, 1);
    chk("busy_before_pop", busy, 1);
    @(negedge clk);
    chk("busy_after_pop", busy, 0);
    wait_idle();

    // Write with stalls, read back including untouched neighbours
    write_burst(6'h10, 4'd3, 32'h5500_0000, 1'b1);
    wait_idle();
    send_req(1'b0, 6'h0F, 4'd5);
    wait_idle();

    // Backpressure: only four reads may be outstanding
    rd_ready = 1'b0;
    send_req(1'b0, 6'h30, 4'd7);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("bp_ram_adr", ram_adr, 6'h34);
    chk("bp_ram_we", ram_we, 0);
    chk("bp_ram_cs", ram_cs, 1);
    chk("bp_rd_valid", rd_valid, 1);
    repeat (5) @(negedge clk);
    chk("bp_ram_adr_held", ram_adr, 6'h34);
    chk("bp_queue_left", rq.size(), 8);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    wait_idle();

    // Reset during the third beat of a long read
    send_req(1'b0, 6'h20, 4'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rq.delete();
    ref_mem[0] = CLOB;
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_rd_valid", rd_valid, 0);
    end
    @(posedge clk); #1;
    send_req(1'b0, 6'h10, 4'd3);
    wait_idle();
    chk("post_rst_drained", rq.size(), 0);

    chk("ram_unknown_warn", ram_warn, 0);
    chk("ram_hygiene", hyg_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
